// File: rtl/arb_dly_ctrl_pkg.sv
// Shared types and default sizing for the arbiter-driven delay-code loop.
package arb_dly_ctrl_pkg;

  localparam int CODE_W_DEF       = 8;
  localparam int WIN_MAX_LOG2_DEF = 10;
  localparam int LOCK_N_DEF       = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_ACCUM  = 2'd2,
    ST_UPDATE = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    DEC_HOLD = 2'd0,
    DEC_UP   = 2'd1,
    DEC_DN   = 2'd2
  } dec_e;

endpackage

// File: rtl/arb_dly_ctrl_if.sv
// Control/status bundle between the loop controller and its host.
interface arb_dly_ctrl_if
  import arb_dly_ctrl_pkg::*;
#(
  parameter int CODE_W       = CODE_W_DEF,
  parameter int WIN_MAX_LOG2 = WIN_MAX_LOG2_DEF
);
  logic                    en;
  logic                    arb_out;
  logic                    load;
  logic [CODE_W-1:0]       init_code;
  logic [3:0]              win_log2;
  logic [WIN_MAX_LOG2-1:0] deadband;
  logic [2:0]              step;
  logic [3:0]              settle;
  logic [CODE_W-1:0]       code;
  logic                    code_upd;
  logic                    lock;
  logic                    sat_hi;
  logic                    sat_lo;

  modport master (
    output en, arb_out, load, init_code, win_log2, deadband, step, settle,
    input  code, code_upd, lock, sat_hi, sat_lo
  );

  modport slave (
    input  en, arb_out, load, init_code, win_log2, deadband, step, settle,
    output code, code_upd, lock, sat_hi, sat_lo
  );
endinterface

// File: rtl/arb_win_cnt.sv
// Accumulation window: counts down W samples and tallies arbiter ones.
module arb_win_cnt
  import arb_dly_ctrl_pkg::*;
#(
  parameter int WIN_MAX_LOG2 = WIN_MAX_LOG2_DEF
) (
  input  logic                  clk,
  input  logic                  rstb,
  input  logic                  start_i,
  input  logic [3:0]            win_log2_i,
  input  logic                  sample_i,
  input  logic                  bit_i,
  output logic                  done_o,
  output logic [WIN_MAX_LOG2:0] ones_o,
  output logic [WIN_MAX_LOG2:0] half_o
);
  localparam int CNT_W = WIN_MAX_LOG2 + 1;

  logic [CNT_W-1:0] rem_q, rem_d;
  logic [CNT_W-1:0] ones_q, ones_d;
  logic [CNT_W-1:0] half_q, half_d;
  logic [3:0]       wl_clamp;
  logic [CNT_W-1:0] win_size;

  always_comb begin
    wl_clamp = win_log2_i;
    if (int'(win_log2_i) > WIN_MAX_LOG2) wl_clamp = 4'(WIN_MAX_LOG2);
    // win_log2 of 0 naturally yields a one-sample window
    win_size = CNT_W'(1) << wl_clamp;

    rem_d  = rem_q;
    ones_d = ones_q;
    half_d = half_q;
    if (start_i) begin
      rem_d  = win_size;
      ones_d = '0;
      half_d = win_size >> 1;
    end else if (sample_i && (rem_q != '0)) begin
      rem_d  = rem_q - CNT_W'(1);
      ones_d = ones_q + CNT_W'(bit_i);
    end
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      rem_q  <= '0;
      ones_q <= '0;
      half_q <= '0;
    end else begin
      rem_q  <= rem_d;
      ones_q <= ones_d;
      half_q <= half_d;
    end
  end

  assign done_o = sample_i && !start_i && (rem_q == CNT_W'(1));
  assign ones_o = ones_q;
  assign half_o = half_q;
endmodule

// File: rtl/arb_dly_ctrl.sv
// Delay-code loop: settle, accumulate arbiter votes, then step the code
// up/down or hold, tracking consecutive holds for lock.
//   state     | meaning
//   ST_IDLE   | loop disabled, code held
//   ST_SETTLE | discard samples while the delay line settles
//   ST_ACCUM  | count arbiter ones over W samples
//   ST_UPDATE | one-cycle decision and code step
module arb_dly_ctrl
  import arb_dly_ctrl_pkg::*;
#(
  parameter int CODE_W       = CODE_W_DEF,
  parameter int WIN_MAX_LOG2 = WIN_MAX_LOG2_DEF,
  parameter int LOCK_N       = LOCK_N_DEF
) (
  input logic           clk,
  input logic           rstb,
  arb_dly_ctrl_if.slave ctl
);
  localparam int LCNT_W = $clog2(LOCK_N + 1);
  localparam int CMP_W  = WIN_MAX_LOG2 + 3;
  localparam int SUM_W  = CODE_W + 1;

  state_e                  state_q, state_d;
  logic [3:0]              settle_cnt_q, settle_cnt_d;
  logic [CODE_W-1:0]       code_q, code_d;
  logic                    upd_q, upd_d;
  logic [LCNT_W-1:0]       lock_cnt_q, lock_cnt_d;
  logic [WIN_MAX_LOG2-1:0] dead_q, dead_d;
  logic [2:0]              step_q, step_d;

  logic                    win_start;
  logic                    win_done;
  logic [WIN_MAX_LOG2:0]   ones;
  logic [WIN_MAX_LOG2:0]   half;
  logic                    restart;

  dec_e                    dec;
  logic signed [CMP_W-1:0] ones_s, thr_hi, thr_lo;
  logic [SUM_W-1:0]        up_sum;
  logic [CODE_W-1:0]       up_code, dn_code;

  arb_win_cnt #(.WIN_MAX_LOG2(WIN_MAX_LOG2)) u_win (
    .clk        (clk),
    .rstb       (rstb),
    .start_i    (win_start),
    .win_log2_i (ctl.win_log2),
    .sample_i   (state_q == ST_ACCUM),
    .bit_i      (ctl.arb_out),
    .done_o     (win_done),
    .ones_o     (ones),
    .half_o     (half)
  );

  // Signed compare so a deadband wider than W/2 never produces a down vote
  always_comb begin
    ones_s = $signed({2'b00, ones});
    thr_hi = $signed({2'b00, half}) + $signed({3'b000, dead_q});
    thr_lo = $signed({2'b00, half}) - $signed({3'b000, dead_q});
    if (ones_s > thr_hi)      dec = DEC_UP;
    else if (ones_s < thr_lo) dec = DEC_DN;
    else                      dec = DEC_HOLD;

    up_sum  = {1'b0, code_q} + SUM_W'(step_q);
    up_code = up_sum[CODE_W] ? '1 : up_sum[CODE_W-1:0];
    dn_code = (code_q < CODE_W'(step_q)) ? '0 : code_q - CODE_W'(step_q);
  end

  always_comb begin
    state_d      = state_q;
    settle_cnt_d = settle_cnt_q;
    code_d       = code_q;
    upd_d        = 1'b0;
    lock_cnt_d   = lock_cnt_q;
    dead_d       = dead_q;
    step_d       = step_q;
    win_start    = 1'b0;
    restart      = 1'b0;

    unique case (state_q)
      ST_IDLE: restart = 1'b1;
      ST_SETTLE: begin
        if (settle_cnt_q <= 4'd1) begin
          state_d   = ST_ACCUM;
          win_start = 1'b1;
        end else begin
          settle_cnt_d = settle_cnt_q - 4'd1;
        end
      end
      ST_ACCUM: begin
        if (win_done) begin
          state_d = ST_UPDATE;
          dead_d  = ctl.deadband;
          step_d  = (ctl.step == 3'd0) ? 3'd1 : ctl.step;
        end
      end
      ST_UPDATE: begin
        restart = 1'b1;
        if (dec == DEC_UP)      code_d = up_code;
        else if (dec == DEC_DN) code_d = dn_code;
        upd_d = (code_d != code_q);
        if (dec != DEC_HOLD)                         lock_cnt_d = '0;
        else if (lock_cnt_q != LCNT_W'(LOCK_N))      lock_cnt_d = lock_cnt_q + LCNT_W'(1);
      end
      default: state_d = ST_IDLE;
    endcase

    if (ctl.load) begin
      code_d     = ctl.init_code;
      upd_d      = 1'b0;
      lock_cnt_d = '0;
      restart    = 1'b1;
    end

    if (!ctl.en) begin
      state_d    = ST_IDLE;
      code_d     = ctl.load ? ctl.init_code : code_q;
      upd_d      = 1'b0;
      lock_cnt_d = '0;
      win_start  = 1'b0;
    end else if (restart) begin
      settle_cnt_d = ctl.settle;
      if (ctl.settle == 4'd0) begin
        state_d   = ST_ACCUM;
        win_start = 1'b1;
      end else begin
        state_d   = ST_SETTLE;
        win_start = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state_q      <= ST_IDLE;
      settle_cnt_q <= '0;
      code_q       <= '0;
      upd_q        <= 1'b0;
      lock_cnt_q   <= '0;
      dead_q       <= '0;
      step_q       <= '0;
    end else begin
      state_q      <= state_d;
      settle_cnt_q <= settle_cnt_d;
      code_q       <= code_d;
      upd_q        <= upd_d;
      lock_cnt_q   <= lock_cnt_d;
      dead_q       <= dead_d;
      step_q       <= step_d;
    end
  end

  assign ctl.code     = code_q;
  assign ctl.code_upd = upd_q;
  assign ctl.lock     = (lock_cnt_q == LCNT_W'(LOCK_N));
  assign ctl.sat_hi   = &code_q;
  assign ctl.sat_lo   = ~|code_q;
endmodule

// File: tb/tb_arb_dly_ctrl.sv
// Directed bench: one-window decision table plus multi-window sequences.
module tb_arb_dly_ctrl;
  import arb_dly_ctrl_pkg::*;

  logic clk  = 1'b0;
  logic rstb = 1'b0;
  always #5 clk = ~clk;

  arb_dly_ctrl_if ifc ();
  arb_dly_ctrl dut (.clk(clk), .rstb(rstb), .ctl(ifc));

  typedef struct {
    int init; int wl; int w; int db; int st; int ones; int exp_code; int exp_upd;
  } vec_t;

  vec_t vecs [23] = '{
    '{128, 4,   16,  2, 1,  16, 129, 1},
    '{128, 4,   16,  2, 1,  11, 129, 1},
    '{128, 4,   16,  2, 1,  10, 128, 0},
    '{128, 4,   16,  2, 1,   5, 127, 1},
    '{128, 4,   16,  2, 1,   6, 128, 0},
    '{128, 4,   16,  0, 1,   8, 128, 0},
    '{128, 4,   16,  0, 1,   9, 129, 1},
    '{128, 4,   16,  0, 1,   7, 127, 1},
    '{128, 4,   16,  2, 0,  16, 129, 1},
    '{128, 4,   16,  2, 7,  16, 135, 1},
    '{  2, 4,   16,  2, 7,   0,   0, 1},
    '{  0, 4,   16,  2, 1,   0,   0, 0},
    '{254, 4,   16,  2, 3,  16, 255, 1},
    '{255, 4,   16,  2, 1,  16, 255, 0},
    '{128, 4,   16, 12, 1,   0, 128, 0},
    '{128, 4,   16,  8, 1,   0, 128, 0},
    '{128, 2,    4,  0, 1,   3, 129, 1},
    '{128, 2,    4,  0, 1,   2, 128, 0},
    '{128, 0,    1,  0, 1,   1, 129, 1},
    '{128, 0,    1,  0, 1,   0, 128, 0},
    '{128, 12, 1024, 0, 1, 513, 129, 1},
    '{128, 12, 1024, 0, 1, 512, 128, 0},
    '{ 10, 4,   16,  0, 7,   0,   3, 1}
  };

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input int init, input int wl, input int db, input int st);
    ifc.init_code = 8'(init);
    ifc.win_log2  = 4'(wl);
    ifc.deadband  = 10'(db);
    ifc.step      = 3'(st);
    ifc.load      = 1'b1;
    tick();
    ifc.load      = 1'b0;
  endtask

  // w samples (first n ones, or alternating 0/1), then the UPDATE cycle
  task automatic run_window(input int w, input int n, input bit alt);
    for (int i = 0; i < w; i++) begin
      ifc.arb_out = alt ? ((i % 2) == 1) : (i < n);
      tick();
    end
    ifc.arb_out = 1'b0;
    tick();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int pc[3];
    int pv[3];
    int np;
    int cyc;
    bit saw;

    ifc.en = 1'b0; ifc.arb_out = 1'b0; ifc.load = 1'b0; ifc.init_code = '0;
    ifc.win_log2 = 4'd4; ifc.deadband = '0; ifc.step = 3'd1; ifc.settle = 4'd0;

    tick(); tick();
    chk("rst code", ifc.code, 0);
    chk("rst code_upd", ifc.code_upd, 0);
    chk("rst lock", ifc.lock, 0);
    chk("rst sat_lo", ifc.sat_lo, 1);
    chk("rst sat_hi", ifc.sat_hi, 0);
    #3 rstb = 1'b1;
    tick();
    ifc.en = 1'b1;

    for (int i = 0; i < 23; i++) begin
      do_load(vecs[i].init, vecs[i].wl, vecs[i].db, vecs[i].st);
      run_window(vecs[i].w, vecs[i].ones, 1'b0);
      chk($sformatf("vec%0d code", i), ifc.code, vecs[i].exp_code);
      chk($sformatf("vec%0d code_upd", i), ifc.code_upd, vecs[i].exp_upd);
      chk($sformatf("vec%0d sat_hi", i), ifc.sat_hi, (vecs[i].exp_code == 255) ? 1 : 0);
      chk($sformatf("vec%0d sat_lo", i), ifc.sat_lo, (vecs[i].exp_code == 0) ? 1 : 0);
      chk($sformatf("vec%0d lock", i), ifc.lock, 0);
      tick();
      chk($sformatf("vec%0d upd_pulse_len", i), ifc.code_upd, 0);
    end

    // Continuous all-ones: one step every W+1 cycles
    do_load(128, 4, 2, 1);
    ifc.arb_out = 1'b1;
    np = 0;
    for (int c = 1; c <= 60; c++) begin
      tick();
      if (ifc.code_upd) begin
        if (np < 3) begin pc[np] = c; pv[np] = int'(ifc.code); end
        np++;
      end
    end
    ifc.arb_out = 1'b0;
    chk("ramp pulse count", np, 3);
    for (int k = 0; k < 3 && k < np; k++) begin
      chk($sformatf("ramp pulse%0d cycle", k), pc[k], 17 * (k + 1));
      chk($sformatf("ramp pulse%0d code", k), pv[k], 129 + k);
    end

    // Lock after four holds, dropped by an up decision
    do_load(100, 4, 0, 1);
    for (int k = 1; k <= 4; k++) begin
      run_window(16, 0, 1'b1);
      chk($sformatf("lock hold%0d", k), ifc.lock, (k == 4) ? 1 : 0);
      chk($sformatf("lock hold%0d code", k), ifc.code, 100);
      chk($sformatf("lock hold%0d upd", k), ifc.code_upd, 0);
    end
    run_window(16, 16, 1'b0);
    chk("lock drop", ifc.lock, 0);
    chk("lock drop code", ifc.code, 101);
    chk("lock drop upd", ifc.code_upd, 1);

    // Saturation at the top clears the hold streak without a pulse
    do_load(254, 4, 0, 3);
    run_window(16, 16, 1'b0);
    chk("sat code", ifc.code, 255);
    chk("sat upd", ifc.code_upd, 1);
    chk("sat sat_hi", ifc.sat_hi, 1);
    for (int k = 0; k < 3; k++) run_window(16, 0, 1'b1);
    chk("sat pre lock", ifc.lock, 0);
    run_window(16, 16, 1'b0);
    chk("sat again upd", ifc.code_upd, 0);
    chk("sat again code", ifc.code, 255);
    run_window(16, 0, 1'b1);
    chk("sat streak cleared", ifc.lock, 0);
    for (int k = 0; k < 3; k++) run_window(16, 0, 1'b1);
    chk("sat relock", ifc.lock, 1);

    // Asynchronous reset in the middle of a window
    ifc.arb_out = 1'b1;
    for (int k = 0; k < 8; k++) tick();
    #2 rstb = 1'b0;
    #1;
    chk("async rst code", ifc.code, 0);
    chk("async rst upd", ifc.code_upd, 0);
    chk("async rst lock", ifc.lock, 0);
    chk("async rst sat_lo", ifc.sat_lo, 1);
    chk("async rst sat_hi", ifc.sat_hi, 0);
    ifc.en = 1'b0;
    ifc.arb_out = 1'b0;
    tick(); tick();
    rstb = 1'b1;
    tick();

    // Abort mid-window, then restart with settling
    ifc.en = 1'b1;
    ifc.settle = 4'd0;
    do_load(50, 4, 2, 1);
    ifc.arb_out = 1'b1;
    for (int k = 0; k < 7; k++) tick();
    ifc.en = 1'b0;
    saw = 1'b0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (ifc.code_upd) saw = 1'b1;
    end
    chk("abort no upd", saw, 0);
    chk("abort code held", ifc.code, 50);
    ifc.settle = 4'd3;
    ifc.en = 1'b1;
    tick();
    cyc = 0;
    saw = 1'b0;
    for (int k = 1; k <= 40 && !saw; k++) begin
      tick();
      if (ifc.code_upd) begin saw = 1'b1; cyc = k; end
    end
    chk("restart upd seen", saw, 1);
    chk("restart latency", cyc, 20);
    chk("restart code", ifc.code, 51);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/arb_dly_ctrl.md
ARB_DLY_CTRL -- requirements
Module: arb_dly_ctrl

Interface
REQ-001 Parameter: CODE_W, 8, delay-code width.
REQ-002 Parameter: WIN_MAX_LOG2, 10, largest accumulation window is 2^WIN_MAX_LOG2 samples.
REQ-003 Parameter: LOCK_N, 4, consecutive hold decisions required to assert lock.
REQ-004 Port: clk  input  1  single clock for all logic; arbiter decision is sampled on its rising edge.
REQ-005 Port: rstb  input  1  asynchronous, active-low reset.
REQ-006 Port: en  input  1  loop enable.
REQ-007 Port: arb_out  input  1  registered arbiter decision; 1 = in1 arrived first, meaning the delay must increase.
REQ-008 Port: load  input  1  single-cycle pulse that loads init_code.
REQ-009 Port: init_code  input  CODE_W  value loaded into code on load.
REQ-010 Port: win_log2  input  4  window W = 2^win_log2 samples; 0 is treated as 1; values above WIN_MAX_LOG2 clamp to WIN_MAX_LOG2.
REQ-011 Port: deadband  input  WIN_MAX_LOG2  hysteresis in samples around W/2.
REQ-012 Port: step  input  3  code increment per decision; 0 is treated as 1.
REQ-013 Port: settle  input  4  cycles discarded after each code change or restart.
REQ-014 Port: code  output  CODE_W  delay-line control code.
REQ-015 Port: code_upd  output  1  one-cycle pulse when code changes by a decision.
REQ-016 Port: lock  output  1  loop locked.
REQ-017 Port: sat_hi / sat_lo  output  1 each  code == 2^CODE_W-1 / code == 0, decoded combinationally from code.

Function
REQ-018 FSM states: IDLE, SETTLE, ACCUM, UPDATE.
REQ-019 IDLE->SETTLE when en=1; when settle=0, go directly IDLE->ACCUM.
REQ-020 SETTLE lasts exactly settle cycles, ignores arb_out, then moves to ACCUM.
REQ-021 ACCUM samples arb_out on each of exactly W cycles into ones counter (WIN_MAX_LOG2+1 bits, cleared on ACCUM entry), then moves to UPDATE.
REQ-022 UPDATE lasts one cycle and produces a decision: ones > W/2+deadband -> up; ones < W/2-deadband, evaluated signed (never true if deadband >= W/2) -> down; otherwise hold.
REQ-023 Up: code <= min(code+step, 2^CODE_W-1). Down: code <= max(code-step, 0). Both use no wrap-around.
REQ-024 code and code_upd are registered at the edge leaving UPDATE; code_upd=1 only if code value actually changes, so a saturated up/down gives no pulse.
REQ-025 UPDATE->SETTLE (or ->ACCUM when settle=0); decision period is W+1+settle cycles.
REQ-026 lock counter counts consecutive hold decisions, saturating at LOCK_N; lock=1 while count==LOCK_N.
REQ-027 A non-hold decision (including a saturated one), load, or en=0 clears the lock counter and lock.
REQ-028 en=0 in any state moves to IDLE next cycle, discards the partial window, and holds code; re-enable restarts from SETTLE.
REQ-029 load in any state: code <= init_code; load has priority over a same-cycle UPDATE result; no code_upd pulse; FSM moves to SETTLE (or ACCUM if settle=0) when en=1, else IDLE.
REQ-030 win_log2, deadband, step and settle are sampled at ACCUM/UPDATE/SETTLE entry respectively; mid-phase changes take effect from the next phase.

Reset
REQ-031 rstb=0 asynchronously forces: state IDLE, code 0, code_upd 0, lock 0, all counters 0; sat_lo therefore 1.
REQ-032 Release is synchronous to clk; the first transition out of IDLE is the clk edge after rstb=1 with en=1.

Structure
REQ-033 Package arb_dly_ctrl_pkg holds the state enum, decision enum (UP/DN/HOLD), and default parameter constants.
REQ-034 Sub-module arb_win_cnt contains the window sample counter and ones counter, with start/done handshake to the FSM.

Verification
REQ-035 Reset with rstb=0 mid-ACCUM -> code=0, code_upd=0, lock=0, sat_lo=1 immediately, without waiting for clk.
REQ-036 load init_code=128, en=1, win_log2=4, deadband=2, step=1, settle=0, arb_out=1 -> code 129,130,131 with code_upd pulses every 17 cycles.
REQ-037 Same setup with 11 ones per window -> up; with 10 ones per window -> hold; with 5 ones -> down.
REQ-038 arb_out alternating, deadband=0, W=16 -> hold each window; lock rises after 4th UPDATE; one all-ones window -> lock drops and code+1.
REQ-039 init_code=254, step=3, all ones -> code 255, sat_hi=1; next window gives no code_upd and lock counter cleared.
REQ-040 en dropped at ACCUM cycle 8 -> no update, IDLE; re-enable with settle=3 -> first code_upd W+1+3 cycles later.
